regpair_sequencer: RTL

//  Upstream access stage for register_file. Turns one 16-bit pair request into

---
 rtl/gb80_regfile_pkg.sv | 64 ++++++
 rtl/regpair_incdec.sv | 18 +
 rtl/regpair_sequencer.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/gb80_regfile_pkg.sv
// Shared definitions for the GB80 register-file access path.
//   - request op, pair and post-modify codes
//   - 8-bit register codes B..A (3'h6 is the memory slot and is never driven here)
//   - sequencer state encoding
//   - helpers mapping a pair code to its hi/lo register codes
package gb80_regfile_pkg;

  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_WRITE = 2'b01,
    OP_INC   = 2'b10,
    OP_DEC   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    PAIR_BC   = 2'b00,
    PAIR_DE   = 2'b01,
    PAIR_HL   = 2'b10,
    PAIR_RSVD = 2'b11
  } pair_e;

  typedef enum logic [1:0] {
    POST_NONE = 2'b00,
    POST_INC  = 2'b01,
    POST_DEC  = 2'b10,
    POST_RSVD = 2'b11
  } post_mod_e;

  localparam logic [2:0] REG_B      = 3'h0;
  localparam logic [2:0] REG_C      = 3'h1;
  localparam logic [2:0] REG_D      = 3'h2;
  localparam logic [2:0] REG_E      = 3'h3;
  localparam logic [2:0] REG_H      = 3'h4;
  localparam logic [2:0] REG_L      = 3'h5;
  localparam logic [2:0] REG_MEMORY = 3'h6;
  localparam logic [2:0] REG_A      = 3'h7;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD_LO  = 3'd1,
    ST_RD_HI  = 3'd2,
    ST_RD_CAP = 3'd3,
    ST_WR_LO  = 3'd4,
    ST_WR_HI  = 3'd5,
    ST_DONE   = 3'd6
  } state_e;

  function automatic logic [2:0] pair_hi_reg(input pair_e pair);
    case (pair)
      PAIR_DE: pair_hi_reg = REG_D;
      PAIR_HL: pair_hi_reg = REG_H;
      default: pair_hi_reg = REG_B;
    endcase
  endfunction

  function automatic logic [2:0] pair_lo_reg(input pair_e pair);
    case (pair)
      PAIR_DE: pair_lo_reg = REG_E;
      PAIR_HL: pair_lo_reg = REG_L;
      default: pair_lo_reg = REG_C;
    endcase
  endfunction

endpackage

// File: rtl/regpair_incdec.sv
// Combinational +1 / -1 on a register-pair value, wrapping modulo 2^WIDTH.
// Shared by INC/DEC requests and the HL post-modify writeback.
//   i_value  in   WIDTH  value to modify
//   i_dec    in   1      0 = increment, 1 = decrement
//   o_value  out  WIDTH  modified value
module regpair_incdec
  import gb80_regfile_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] i_value,
  input  logic             i_dec,
  output logic [WIDTH-1:0] o_value
);

  assign o_value = i_dec ? (i_value - WIDTH'(1)) : (i_value + WIDTH'(1));

endmodule

// File: rtl/regpair_sequencer.sv
// Upstream access stage for register_file: turns one 16-bit pair request
// (READ/WRITE/INC/DEC on BC, DE or HL) into back-to-back 8-bit register_file
// cycles, low byte first.
// Optional feature macro: REGPAIR_HLI_EN -- READ of HL with i_post_mod 01/10
// also writes back HL+1 / HL-1 (o_rdata keeps the pre-modified value).
// Ports:
//   i_clk, i_reset         clock (rising edge), asynchronous active-low reset
//   i_req_valid/o_req_ready request handshake, ready only in IDLE
//   i_op, i_pair, i_post_mod, i_wdata   request fields, captured on accept
//   o_rdata                READ: pair value, INC/DEC: new value
//   o_done, o_err          one-cycle completion pulse, error = reserved pair
//   o_rf_addr/o_rf_rd_en/o_rf_wr_en/o_rf_wdata   to register_file
//   i_rf_rdata             from register_file, valid the cycle after rd_en
module regpair_sequencer
  import gb80_regfile_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned ADDRESS_WIDTH = 3
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_req_valid,
  output logic                      o_req_ready,
  input  logic [1:0]                i_op,
  input  logic [1:0]                i_pair,
  input  logic [1:0]                i_post_mod,
  input  logic [2*DATA_WIDTH-1:0]   i_wdata,
  output logic [2*DATA_WIDTH-1:0]   o_rdata,
  output logic                      o_done,
  output logic                      o_err,
  output logic [ADDRESS_WIDTH-1:0]  o_rf_addr,
  output logic                      o_rf_rd_en,
  output logic                      o_rf_wr_en,
  output logic [DATA_WIDTH-1:0]     o_rf_wdata,
  input  logic [DATA_WIDTH-1:0]     i_rf_rdata
);

  localparam int unsigned PW = 2 * DATA_WIDTH;

  state_e                state;
  pair_e                 pair_q;
  logic                  wb_q;       // read path continues into a writeback
  logic                  dec_q;      // writeback direction
  logic                  ret_new_q;  // o_rdata reports the modified value
  logic                  err_q;
  logic [DATA_WIDTH-1:0] lo_q;
  logic [PW-1:0]         wr_q;

  logic [PW-1:0]         rd_value;
  logic [PW-1:0]         mod_value;

  logic                  acc_wb;
  logic                  acc_dec;
  logic                  acc_ret_new;

  // Full pair is only complete in RD_CAP, when the hi byte arrives.
  assign rd_value = {i_rf_rdata, lo_q};

  regpair_incdec #(.WIDTH(PW)) u_incdec (
    .i_value (rd_value),
    .i_dec   (dec_q),
    .o_value (mod_value)
  );

  // Decode of the request being accepted into the read-modify-write controls.
  always_comb begin
    acc_wb      = (op_e'(i_op) == OP_INC) || (op_e'(i_op) == OP_DEC);
    acc_dec     = (op_e'(i_op) == OP_DEC);
    acc_ret_new = acc_wb;
`ifdef REGPAIR_HLI_EN
    if ((op_e'(i_op) == OP_READ) && (pair_e'(i_pair) == PAIR_HL) &&
        ((post_mod_e'(i_post_mod) == POST_INC) || (post_mod_e'(i_post_mod) == POST_DEC))) begin
      acc_wb      = 1'b1;
      acc_dec     = (post_mod_e'(i_post_mod) == POST_DEC);
      acc_ret_new = 1'b0;
    end
`endif
  end

`ifndef REGPAIR_HLI_EN
  logic post_mod_unused;
  assign post_mod_unused = ^i_post_mod;
`endif

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state     <= ST_IDLE;
      pair_q    <= PAIR_BC;
      wb_q      <= 1'b0;
      dec_q     <= 1'b0;
      ret_new_q <= 1'b0;
      err_q     <= 1'b0;
      lo_q      <= '0;
      wr_q      <= '0;
      o_rdata   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_req_valid) begin
            pair_q    <= pair_e'(i_pair);
            wb_q      <= acc_wb;
            dec_q     <= acc_dec;
            ret_new_q <= acc_ret_new;
            err_q     <= 1'b0;
            wr_q      <= i_wdata;
            if (pair_e'(i_pair) == PAIR_RSVD) begin
              err_q <= 1'b1;
              state <= ST_DONE;
            end else if (op_e'(i_op) == OP_WRITE) begin
              state <= ST_WR_LO;
            end else begin
              state <= ST_RD_LO;
            end
          end
        end
        ST_RD_LO: state <= ST_RD_HI;
        ST_RD_HI: begin
          lo_q  <= i_rf_rdata;
          state <= ST_RD_CAP;
        end
        ST_RD_CAP: begin
          o_rdata <= ret_new_q ? mod_value : rd_value;
          wr_q    <= mod_value;
          state   <= wb_q ? ST_WR_LO : ST_DONE;
        end
        ST_WR_LO: state <= ST_WR_HI;
        ST_WR_HI: state <= ST_DONE;
        ST_DONE:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  assign o_req_ready = (state == ST_IDLE);
  assign o_done      = (state == ST_DONE);
  assign o_err       = (state == ST_DONE) && err_q;

  // Strobes decode straight from state so an asynchronous reset drops them at once.
  always_comb begin
    o_rf_rd_en = 1'b0;
    o_rf_wr_en = 1'b0;
    o_rf_addr  = '0;
    o_rf_wdata = '0;
    case (state)
      ST_RD_LO: begin
        o_rf_rd_en = 1'b1;
        o_rf_addr  = ADDRESS_WIDTH'(pair_lo_reg(pair_q));
      end
      ST_RD_HI: begin
        o_rf_rd_en = 1'b1;
        o_rf_addr  = ADDRESS_WIDTH'(pair_hi_reg(pair_q));
      end
      ST_WR_LO: begin
        o_rf_wr_en = 1'b1;
        o_rf_addr  = ADDRESS_WIDTH'(pair_lo_reg(pair_q));
        o_rf_wdata = wr_q[DATA_WIDTH-1:0];
      end
      ST_WR_HI: begin
        o_rf_wr_en = 1'b1;
        o_rf_addr  = ADDRESS_WIDTH'(pair_hi_reg(pair_q));
        o_rf_wdata = wr_q[PW-1:DATA_WIDTH];
      end
      default: begin
      end
    endcase
  end

endmodule
